// File: rtl/bat_ram_arbiter.sv
// Two-port (CPU / DMA loader) arbiter in front of a single-ported 8-bit RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise CPU has fixed priority.
module bat_ram_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CPU_REQ,
  input  logic       CPU_RW,
  input  logic [7:0] CPU_ADDR,
  input  logic [7:0] CPU_WDATA,
  output logic       CPU_ACK,
  output logic [7:0] CPU_RDATA,
  input  logic       DMA_REQ,
  input  logic       DMA_RW,
  input  logic [7:0] DMA_ADDR,
  input  logic [7:0] DMA_WDATA,
  output logic       DMA_ACK,
  output logic [7:0] DMA_RDATA,
  output logic       RAM_EN,
  output logic       RAM_RW,
  output logic [7:0] RAM_ADDR,
  output logic [7:0] RAM_WDATA,
  input  logic [7:0] RAM_RDATA,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       lat_rw_q, lat_rw_d;
  logic [7:0] lat_addr_q, lat_addr_d;
  logic [7:0] lat_wdata_q, lat_wdata_d;
  logic       ram_en_q, ram_en_d;
  logic       ram_rw_q, ram_rw_d;
  logic [7:0] ram_addr_q, ram_addr_d;
  logic [7:0] ram_wdata_q, ram_wdata_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       dma_ack_q, dma_ack_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] dma_rdata_q, dma_rdata_d;
  logic       busy_q, busy_d;
  logic       pick_dma_s;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_dma_q, last_dma_d;
`endif

  // Arbitration: which port wins when leaving IDLE this cycle.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_dma_s = DMA_REQ && (!CPU_REQ || !last_dma_q);
`else
    pick_dma_s = DMA_REQ && !CPU_REQ;
`endif
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    lat_rw_d    = lat_rw_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    ram_en_d    = 1'b0;
    ram_rw_d    = 1'b1;
    ram_addr_d  = 8'h00;
    ram_wdata_d = 8'h00;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_dma_d  = last_dma_q;
`endif
    case (state_q)
      IDLE: begin
        if (CPU_REQ || DMA_REQ) begin
          lat_rw_d    = pick_dma_s ? DMA_RW    : CPU_RW;
          lat_addr_d  = pick_dma_s ? DMA_ADDR  : CPU_ADDR;
          lat_wdata_d = pick_dma_s ? DMA_WDATA : CPU_WDATA;
          // RAM strobe is registered here so it is live for exactly the GNT cycle.
          ram_en_d    = 1'b1;
          ram_rw_d    = lat_rw_d;
          ram_addr_d  = lat_addr_d;
          ram_wdata_d = lat_wdata_d;
          state_d     = pick_dma_s ? GNT_DMA : GNT_CPU;
`ifdef ARB_ROUND_ROBIN_EN
          last_dma_d  = pick_dma_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GNT_CPU: begin
        cpu_ack_d = 1'b1;
        state_d   = DONE;
      end
      GNT_DMA: begin
        dma_ack_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (cpu_ack_q && lat_rw_q) begin
          cpu_rdata_d = RAM_RDATA;
        end else begin
          cpu_rdata_d = cpu_rdata_q;
        end
        if (dma_ack_q && lat_rw_q) begin
          dma_rdata_d = RAM_RDATA;
        end else begin
          dma_rdata_d = dma_rdata_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; async reset aborts any access in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      lat_rw_q    <= 1'b0;
      lat_addr_q  <= 8'h00;
      lat_wdata_q <= 8'h00;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b1;
      ram_addr_q  <= 8'h00;
      ram_wdata_q <= 8'h00;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      dma_rdata_q <= 8'h00;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dma_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      lat_rw_q    <= lat_rw_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dma_q  <= last_dma_d;
`endif
    end
  end

  // RAM data only arrives in DONE, so it is forwarded during ACK and held afterwards.
  assign CPU_RDATA = (cpu_ack_q && lat_rw_q) ? RAM_RDATA : cpu_rdata_q;
  assign DMA_RDATA = (dma_ack_q && lat_rw_q) ? RAM_RDATA : dma_rdata_q;
  assign CPU_ACK   = cpu_ack_q;
  assign DMA_ACK   = dma_ack_q;
  assign RAM_EN    = ram_en_q;
  assign RAM_RW    = ram_rw_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = ram_wdata_q;
  assign BUSY      = busy_q;

endmodule
